// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-ported register file.
// Contents: default XLEN/NREG, read/write port counts, and the
// port-priority write-address match used by the bypass paths.
package rf_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned N_RD     = 4;
    localparam int unsigned N_WR     = 2;
    // Widest address the match helper accepts; callers zero-extend.
    localparam int unsigned MAX_AW   = 16;

    typedef struct packed {
        logic hit;   // some enabled port targets the address
        logic port;  // index of the winning port (1 = younger)
    } wr_hit_t;

    // Match a nonzero address against two enabled ports; port 1 has priority.
    function automatic wr_hit_t wr_match(
        input logic [MAX_AW-1:0] ra,
        input logic [N_WR-1:0]   en,
        input logic [MAX_AW-1:0] wa0,
        input logic [MAX_AW-1:0] wa1
    );
        wr_hit_t r;
        r = '0;
        if (ra != '0) begin
            if (en[1] && wa1 == ra) begin
                r.hit  = 1'b1;
                r.port = 1'b1;
            end else if (en[0] && wa0 == ra) begin
                r.hit  = 1'b1;
                r.port = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by alloc, cleared by
// write-back, with alloc taking priority. Bit 0 is never pending.
// Ports: clk, rst (sync, active-high); rd_addr -> rd_busy lookups (4);
// we/wr_addr clear, alloc_en/alloc_addr set (2 each).
// Optional: RF_BYPASS_EN masks busy on a same-cycle write unless a
// same-cycle alloc targets the register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_RD*AW-1:0]   rd_addr,
    input  logic [N_WR-1:0]      we,
    input  logic [N_WR*AW-1:0]   wr_addr,
    input  logic [N_WR-1:0]      alloc_en,
    input  logic [N_WR*AW-1:0]   alloc_addr,
    output logic [N_RD-1:0]      rd_busy
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Clears first, then sets, so a same-cycle alloc leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        for (int unsigned i = 0; i < N_WR; i++) begin
            if (we[i]) pending_nxt[wr_addr[i*AW +: AW]] = 1'b0;
        end
        for (int unsigned i = 0; i < N_WR; i++) begin
            if (alloc_en[i]) pending_nxt[alloc_addr[i*AW +: AW]] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    // Busy lookups per read port.
    always_comb begin
        logic [AW-1:0] ra;
        ra      = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            ra         = rd_addr[k*AW +: AW];
            rd_busy[k] = (ra != '0) && pending[ra];
`ifdef RF_BYPASS_EN
            if (wr_match(MAX_AW'(ra), we,
                         MAX_AW'(wr_addr[0 +: AW]), MAX_AW'(wr_addr[AW +: AW])).hit &&
                !wr_match(MAX_AW'(ra), alloc_en,
                          MAX_AW'(alloc_addr[0 +: AW]), MAX_AW'(alloc_addr[AW +: AW])).hit)
                rd_busy[k] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file for the dual-issue pipeline: 4 async read
// ports, 2 sync write ports (port 1 = younger, wins on collision), r0
// hard-wired to zero, plus a pending-write scoreboard (rf_scoreboard).
// Ports: clk, rst (sync, active-high); rd_addr/rd_data/rd_busy (4 ports);
// we/wr_addr/wr_data (2 ports); alloc_en/alloc_addr (2 ports).
// Optional: RF_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_RD*AW-1:0]     rd_addr,
    output logic [N_RD*XLEN-1:0]   rd_data,
    output logic [N_RD-1:0]        rd_busy,
    input  logic [N_WR-1:0]        we,
    input  logic [N_WR*AW-1:0]     wr_addr,
    input  logic [N_WR*XLEN-1:0]   wr_data,
    input  logic [N_WR-1:0]        alloc_en,
    input  logic [N_WR*AW-1:0]     alloc_addr
);

    logic [XLEN-1:0] mem [NREG];

    // Port 1 is applied last so it overrides port 0 on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else begin
            for (int unsigned i = 0; i < N_WR; i++) begin
                if (we[i] && wr_addr[i*AW +: AW] != '0)
                    mem[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
            end
        end
    end

    // Read muxes; r0 always reads zero.
    always_comb begin
        logic [AW-1:0] ra;
`ifdef RF_BYPASS_EN
        wr_hit_t hit;
        hit = '0;
`endif
        ra      = '0;
        rd_data = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            ra = rd_addr[k*AW +: AW];
            if (ra != '0) rd_data[k*XLEN +: XLEN] = mem[ra];
`ifdef RF_BYPASS_EN
            hit = wr_match(MAX_AW'(ra), we,
                           MAX_AW'(wr_addr[0 +: AW]), MAX_AW'(wr_addr[AW +: AW]));
            if (hit.hit)
                rd_data[k*XLEN +: XLEN] = hit.port ? wr_data[XLEN +: XLEN]
                                                   : wr_data[0 +: XLEN];
`endif
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .we         (we),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .rd_busy    (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed cases with literal
// expectations, then a random dual-issue stream against a behavioural model.
module tb_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [4*AW-1:0]   rd_addr;
    logic [4*XLEN-1:0] rd_data;
    logic [3:0]        rd_busy;
    logic [1:0]        we;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic [1:0]        alloc_en;
    logic [2*AW-1:0]   alloc_addr;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural register values and the set of
    // registers with an in-flight producer.
    logic [XLEN-1:0] m_val [NREG];
    bit              m_busy [NREG];

    function automatic logic [AW-1:0] wa(input int i);
        return wr_addr[i*AW +: AW];
    endfunction
    function automatic logic [AW-1:0] aa(input int i);
        return alloc_addr[i*AW +: AW];
    endfunction
    function automatic logic [XLEN-1:0] wd(input int i);
        return wr_data[i*XLEN +: XLEN];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_val[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            bit            set_now [NREG];
            bit            clr_now [NREG];
            logic [XLEN-1:0] nv;
            for (int r = 0; r < NREG; r++) begin
                set_now[r] = (alloc_en[0] && aa(0) == AW'(r)) || (alloc_en[1] && aa(1) == AW'(r));
                clr_now[r] = (we[0] && wa(0) == AW'(r)) || (we[1] && wa(1) == AW'(r));
                nv = m_val[r];
                if (we[0] && wa(0) == AW'(r)) nv = wd(0);
                if (we[1] && wa(1) == AW'(r)) nv = wd(1);
                if (r != 0) begin
                    m_val[r] = nv;
                    if (set_now[r])      m_busy[r] = 1'b1;
                    else if (clr_now[r]) m_busy[r] = 1'b0;
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] ra);
        if (ra == '0) return '0;
`ifdef RF_BYPASS_EN
        if (we[1] && wa(1) == ra) return wd(1);
        if (we[0] && wa(0) == ra) return wd(0);
`endif
        return m_val[ra];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] ra);
        if (ra == '0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (((we[0] && wa(0) == ra) || (we[1] && wa(1) == ra)) &&
            !((alloc_en[0] && aa(0) == ra) || (alloc_en[1] && aa(1) == ra)))
            return 1'b0;
`endif
        return m_busy[ra];
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        if (check_en) begin
            #2;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("model_data[%0d]", k), rd_data[k*XLEN +: XLEN],
                    exp_data(rd_addr[k*AW +: AW]));
                chk($sformatf("model_busy[%0d]", k), XLEN'(rd_busy[k]),
                    XLEN'(exp_busy(rd_addr[k*AW +: AW])));
            end
        end
    end

    task automatic idle();
        rst        = 1'b0;
        rd_addr    = '0;
        we         = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = '0;
        alloc_addr = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom);
    endfunction

    logic [XLEN-1:0] exp_byp;

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        idle();
        check_en = 1'b1;

        // Reset state
        set_rd(0, 5, 9, 31);
        #3;
        for (int k = 0; k < 4; k++) begin
            chk("rst_data", rd_data[k*XLEN +: XLEN], 32'h0);
            chk("rst_busy", XLEN'(rd_busy[k]), 32'h0);
        end

        // Write r5, then reset with a write/alloc pending in the reset edge
        @(negedge clk); idle();
        we[0] = 1'b1; wr_addr[0 +: AW] = 5; wr_data[0 +: XLEN] = 32'hDEAD_BEEF;
        @(negedge clk); idle(); set_rd(5, 0, 0, 0);
        #3; chk("wr_r5", rd_data[0 +: XLEN], 32'hDEAD_BEEF);
        @(negedge clk); idle(); rst = 1'b1;
        we[0] = 1'b1; wr_addr[0 +: AW] = 5; wr_data[0 +: XLEN] = 32'h1234_5678;
        alloc_en[0] = 1'b1; alloc_addr[0 +: AW] = 5;
        @(negedge clk); idle(); set_rd(5, 5, 5, 5);
        #3;
        chk("rst_r5_data", rd_data[0 +: XLEN], 32'h0);
        chk("rst_r5_busy", XLEN'(rd_busy), 32'h0);

        // Zero register write and alloc
        @(negedge clk); idle();
        we[0] = 1'b1; wr_addr[0 +: AW] = 0; wr_data[0 +: XLEN] = 32'hFFFF_FFFF;
        alloc_en[0] = 1'b1; alloc_addr[0 +: AW] = 0;
        set_rd(0, 0, 0, 0);
        #3; chk("r0_same_data", rd_data[0 +: XLEN], 32'h0);
        chk("r0_same_busy", XLEN'(rd_busy[0]), 32'h0);
        @(negedge clk); idle(); set_rd(0, 0, 0, 0);
        #3; chk("r0_data", rd_data[0 +: XLEN], 32'h0);
        chk("r0_busy", XLEN'(rd_busy[0]), 32'h0);

        // Dual-write collision: younger port wins
        @(negedge clk); idle();
        we = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {32'h2222, 32'h1111};
        @(negedge clk); idle(); set_rd(0, 7, 0, 0);
        #3; chk("collide_r7", rd_data[XLEN +: XLEN], 32'h2222);

        // Bypass of a write to r3 read on port 2
`ifdef RF_BYPASS_EN
        exp_byp = 32'hABCD;
`else
        exp_byp = 32'h0;
`endif
        @(negedge clk); idle();
        we[0] = 1'b1; wr_addr[0 +: AW] = 3; wr_data[0 +: XLEN] = 32'hABCD;
        set_rd(0, 0, 3, 0);
        #3; chk("byp_same", rd_data[2*XLEN +: XLEN], exp_byp);
        @(negedge clk); idle(); set_rd(0, 0, 3, 0);
        #3; chk("byp_next", rd_data[2*XLEN +: XLEN], 32'hABCD);

        // Scoreboard: alloc, release, alloc-beats-release
        @(negedge clk); idle(); alloc_en[0] = 1'b1; alloc_addr[0 +: AW] = 9;
        @(negedge clk); idle(); set_rd(0, 0, 0, 9);
        #3; chk("alloc_r9", XLEN'(rd_busy[3]), 32'h1);
        @(negedge clk); idle();
        we[0] = 1'b1; wr_addr[0 +: AW] = 9; wr_data[0 +: XLEN] = 32'h55;
        @(negedge clk); idle(); set_rd(0, 0, 0, 9);
        #3; chk("release_r9", XLEN'(rd_busy[3]), 32'h0);
        chk("release_r9_data", rd_data[3*XLEN +: XLEN], 32'h55);
        @(negedge clk); idle();
        we[0] = 1'b1; wr_addr[0 +: AW] = 9; wr_data[0 +: XLEN] = 32'h66;
        alloc_en[1] = 1'b1; alloc_addr[AW +: AW] = 9;
        @(negedge clk); idle(); set_rd(0, 0, 0, 9);
        #3; chk("alloc_wins_r9", XLEN'(rd_busy[3]), 32'h1);
        // Double alloc of r10 is a single set; one write clears it
        @(negedge clk); idle();
        alloc_en = 2'b11; alloc_addr = {AW'(10), AW'(10)};
        @(negedge clk); idle();
        we[1] = 1'b1; wr_addr[AW +: AW] = 10; wr_data[XLEN +: XLEN] = 32'h77;
        @(negedge clk); idle(); set_rd(10, 0, 0, 0);
        #3; chk("dual_alloc_r10", XLEN'(rd_busy[0]), 32'h0);

        // Random dual-issue stream with reset pulses
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst = (i == 3000 || i == 7000 || $urandom_range(0, 999) == 0);
            set_rd(raddr(), raddr(), raddr(), raddr());
            we         = 2'($urandom);
            wr_addr    = {raddr(), raddr()};
            wr_data    = {32'($urandom), 32'($urandom)};
            alloc_en   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
            alloc_addr = {raddr(), raddr()};
        end
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
